// File: rtl/steer_en_multi.sv
// Rider detection and steering enable from a bank of load cells.
// Readings are sampled on ld_vld; a balanced stance held long enough enables steering.
module steer_en_multi #(
    parameter int          NUM_CELLS     = 2,
    parameter int          LD_W          = 12,
    parameter int unsigned MIN_RIDER_WT  = 32'h0000_0200,
    parameter int unsigned WT_HYST       = 32'h0000_0040,
    parameter int unsigned FULL_CYCLES   = 32'd67_000_000,
    parameter bit          FAST_SIM      = 1'b1,
    parameter int unsigned FAST_CYCLES   = 32'd32768,
    parameter int unsigned FAULT_SAMPLES = 32'd4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ld_vld,
    input  logic [NUM_CELLS*LD_W-1:0]            ld_data,
    output logic                                 en_steer,
    output logic                                 rider_off,
    output logic [LD_W+$clog2(NUM_CELLS)-1:0]    rider_wt,
    output logic [1:0]                           state_o,
    output logic [NUM_CELLS-1:0]                 cell_fault
);

    localparam int          SUM_W  = LD_W + $clog2(NUM_CELLS);
    localparam int          HALF   = NUM_CELLS / 2;
    localparam int unsigned TGT    = FAST_SIM ? FAST_CYCLES : FULL_CYCLES;
    localparam int          TMR_W  = (TGT > 32'd1) ? $clog2(TGT) : 1;
    localparam int          CNT_W  = $clog2(FAULT_SAMPLES + 32'd1);
    localparam int unsigned THR_HI = MIN_RIDER_WT + WT_HYST;
    localparam int unsigned THR_LO = (MIN_RIDER_WT > WT_HYST) ? (MIN_RIDER_WT - WT_HYST) : 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_STEER = 2'b10
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_CELLS*LD_W-1:0]   samp_q, samp_d;
    logic [TMR_W-1:0]            tmr_q, tmr_d;
    logic [CNT_W-1:0]            cnt_q [NUM_CELLS];
    logic [CNT_W-1:0]            cnt_d [NUM_CELLS];
    logic [NUM_CELLS-1:0]        fault_q, fault_d;
    logic [SUM_W-1:0]            wt_q, wt_d;
    logic                        en_steer_q, rider_off_q;
    logic [1:0]                  state_o_q;

    logic [SUM_W-1:0]            lsum_s, rsum_s, sum_s, diff_s;
    logic                        sum_gt_min_s, sum_lt_min_s;
    logic                        diff_gt_1_4_s, diff_gt_15_16_s, tmr_full_s;

    // Sum of cells lo..hi-1 of a packed reading vector; SUM_W cannot overflow.
    function automatic logic [SUM_W-1:0] sum_range(
        input logic [NUM_CELLS*LD_W-1:0] v,
        input int                        lo,
        input int                        hi
    );
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (i >= lo && i < hi) begin
                acc = acc + SUM_W'(v[i*LD_W +: LD_W]);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Sample capture, weight/balance arithmetic and threshold flags.
    always_comb begin
        samp_d          = ld_vld ? ld_data : samp_q;
        lsum_s          = sum_range(samp_q, 0, HALF);
        rsum_s          = sum_range(samp_q, HALF, NUM_CELLS);
        sum_s           = lsum_s + rsum_s;
        diff_s          = (rsum_s >= lsum_s) ? (rsum_s - lsum_s) : (lsum_s - rsum_s);
        wt_d            = sum_range(samp_d, 0, NUM_CELLS);
        sum_gt_min_s    = (32'(sum_s) > THR_HI);
        sum_lt_min_s    = (32'(sum_s) < THR_LO);
        diff_gt_1_4_s   = (diff_s > (sum_s >> 2));
        diff_gt_15_16_s = (diff_s > (sum_s - (sum_s >> 4)));
        tmr_full_s      = (tmr_q == TMR_W'(TGT - 32'd1));
    end

    // Per-cell saturation counters; a fault is sticky until reset.
    always_comb begin
        for (int i = 0; i < NUM_CELLS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ld_vld) begin
                if (&ld_data[i*LD_W +: LD_W]) begin
                    if (cnt_q[i] == CNT_W'(FAULT_SAMPLES)) begin
                        cnt_d[i] = cnt_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            fault_d[i] = fault_q[i] | (cnt_d[i] == CNT_W'(FAULT_SAMPLES));
        end
    end

    // Balance-hold timer: runs only in WAIT while balanced, holds at its terminal count.
    always_comb begin
        tmr_d = '0;
        if (state_q == ST_WAIT && !diff_gt_1_4_s) begin
            tmr_d = tmr_full_s ? tmr_q : (tmr_q + TMR_W'(1));
        end else begin
            tmr_d = '0;
        end
    end

    // Next-state logic; a latched cell fault overrides every transition.
    always_comb begin
        state_d = state_q;
        if (|fault_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sum_gt_min_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (sum_lt_min_s) begin
                        state_d = ST_IDLE;
                    end else if (tmr_full_s && !diff_gt_1_4_s) begin
                        state_d = ST_STEER;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_STEER: begin
                    if (sum_lt_min_s) begin
                        state_d = ST_IDLE;
                    end else if (diff_gt_15_16_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_STEER;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, sample, timer, fault and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            samp_q      <= '0;
            tmr_q       <= '0;
            fault_q     <= '0;
            wt_q        <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
            state_o_q   <= 2'b00;
            for (int i = 0; i < NUM_CELLS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            tmr_q       <= tmr_d;
            fault_q     <= fault_d;
            wt_q        <= wt_d;
            en_steer_q  <= (state_d == ST_STEER);
            rider_off_q <= (state_d == ST_IDLE);
            state_o_q   <= state_d;
            for (int i = 0; i < NUM_CELLS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign en_steer   = en_steer_q;
    assign rider_off  = rider_off_q;
    assign rider_wt   = wt_q;
    assign state_o    = state_o_q;
    assign cell_fault = fault_q;

endmodule

// File: tb/tb_steer_en_multi.sv
// Directed and randomized bench for steer_en_multi (2 cells, 12-bit readings, fast timing).
// A cycle-level reference model written with plain integer arithmetic predicts every output.
module tb_steer_en_multi;

    localparam int T = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_vld;
    logic [23:0] ld_data;
    logic        en_steer;
    logic        rider_off;
    logic [12:0] rider_wt;
    logic [1:0]  state_o;
    logic [1:0]  cell_fault;

    int checks = 0;
    int errors = 0;

    // Reference model state: samples, FSM (0 idle, 1 wait, 2 steer), hold timer, fault tracking.
    int m_s0, m_s1, m_state, m_tmr;
    int m_cnt [2];
    int m_flt [2];

    always #5 clk = ~clk;

    steer_en_multi #(
        .NUM_CELLS     (2),
        .LD_W          (12),
        .MIN_RIDER_WT  (32'h200),
        .WT_HYST       (32'h40),
        .FULL_CYCLES   (32'd67_000_000),
        .FAST_SIM      (1'b1),
        .FAST_CYCLES   (32'd32768),
        .FAULT_SAMPLES (32'd4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_vld     (ld_vld),
        .ld_data    (ld_data),
        .en_steer   (en_steer),
        .rider_off  (rider_off),
        .rider_wt   (rider_wt),
        .state_o    (state_o),
        .cell_fault (cell_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s0 = 0; m_s1 = 0; m_state = 0; m_tmr = 0;
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 0;
            m_flt[c] = 0;
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input int a, input int b);
        int sum, diff, ns, val;
        bit gt, lt, d14, d1516;
        if (r) begin
            model_reset();
        end else begin
            sum   = m_s0 + m_s1;
            diff  = (m_s1 >= m_s0) ? (m_s1 - m_s0) : (m_s0 - m_s1);
            gt    = sum > (32'h200 + 32'h40);
            lt    = sum < (32'h200 - 32'h40);
            d14   = diff > (sum / 4);
            d1516 = diff > (sum - sum / 16);
            ns    = m_state;
            if (m_flt[0] != 0 || m_flt[1] != 0) ns = 0;
            else if (m_state == 0) begin
                if (gt) ns = 1;
            end else if (m_state == 1) begin
                if (lt) ns = 0;
                else if (!d14 && m_tmr == T - 1) ns = 2;
            end else begin
                if (lt) ns = 0;
                else if (d1516) ns = 1;
            end
            m_tmr = (m_state == 1 && !d14) ? m_tmr + 1 : 0;
            if (v) begin
                for (int c = 0; c < 2; c++) begin
                    val = (c == 0) ? a : b;
                    if (val == 32'hFFF) m_cnt[c]++;
                    else m_cnt[c] = 0;
                    if (m_cnt[c] >= 4) m_flt[c] = 1;
                end
                m_s0 = a;
                m_s1 = b;
            end
            m_state = ns;
        end
    endtask

    task automatic check_all();
        check("state_o",    32'(state_o),    32'(m_state));
        check("en_steer",   32'(en_steer),   32'(m_state == 2));
        check("rider_off",  32'(rider_off),  32'(m_state == 0));
        check("rider_wt",   32'(rider_wt),   32'(m_s0 + m_s1));
        check("cell_fault", 32'(cell_fault), 32'(m_flt[1] * 2 + m_flt[0]));
    endtask

    task automatic step(input bit r, input bit v, input int a, input int b);
        rst     = r;
        ld_vld  = v;
        ld_data = {12'(b), 12'(a)};
        @(posedge clk);
        model_edge(r, v, a, b);
        #1;
        check_all();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    function automatic int pick();
        if ($urandom_range(0, 5) == 0) return 32'hFFF;
        return int'($urandom_range(0, 32'h3FF));
    endfunction

    initial begin
        model_reset();
        rst = 1'b1; ld_vld = 1'b0; ld_data = 24'h0;

        // Reset, with reset winning over a simultaneous load.
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 12'h150, 12'h150);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_wt", 32'(rider_wt), 32'd0);
        check("rst_off", 32'(rider_off), 32'd1);

        // Hysteresis band seen from IDLE.
        step(1'b0, 1'b1, 12'h0E0, 12'h0E0);
        hold(3);
        check("hyst_idle_lo", 32'(state_o), 32'd0);
        step(1'b0, 1'b1, 12'h120, 12'h120);
        hold(3);
        check("hyst_idle_hi", 32'(state_o), 32'd0);

        // Mount: WAIT two edges after the strobe.
        step(1'b0, 1'b1, 12'h150, 12'h150);
        check("mount_n", 32'(state_o), 32'd0);
        hold(1);
        check("mount_n1", 32'(state_o), 32'd1);

        // Hysteresis band seen from WAIT.
        step(1'b0, 1'b1, 12'h0E0, 12'h0E0);
        hold(3);
        check("hyst_wait_lo", 32'(state_o), 32'd1);
        step(1'b0, 1'b1, 12'h120, 12'h120);
        hold(3);
        check("hyst_wait_hi", 32'(state_o), 32'd1);
        step(1'b0, 1'b1, 12'h150, 12'h150);

        // Reset part-way through WAIT.
        for (int i = 0; i < 5000 && m_tmr != 2000; i++) hold(1);
        check("wait_before_rst", 32'(state_o), 32'd1);
        step(1'b1, 1'b0, 0, 0);
        check("rst_mid_wait", 32'(state_o), 32'd0);
        check("rst_mid_wait_wt", 32'(rider_wt), 32'd0);

        // Remount, imbalance part-way through the hold, then a full re-balance count.
        step(1'b0, 1'b1, 12'h150, 12'h150);
        hold(1);
        for (int i = 0; i < 5000 && m_tmr != 2000; i++) hold(1);
        step(1'b0, 1'b1, 12'h0C0, 12'h1E0);
        hold(1);
        check("imbal_wait", 32'(state_o), 32'd1);
        step(1'b0, 1'b1, 12'h150, 12'h150);
        hold(T - 1);
        check("not_before", 32'(en_steer), 32'd0);
        hold(1);
        check("steer_on", 32'(en_steer), 32'd1);
        check("steer_state", 32'(state_o), 32'd2);

        // Steer exit to WAIT on gross imbalance, then to IDLE on low weight.
        step(1'b0, 1'b1, 12'h000, 12'h2A0);
        hold(1);
        check("exit_wait", 32'(state_o), 32'd1);
        check("exit_en", 32'(en_steer), 32'd0);
        step(1'b0, 1'b1, 12'h0D8, 12'h0D8);
        hold(1);
        check("exit_idle", 32'(rider_off), 32'd1);

        // Three saturated samples broken by a valid one do not fault.
        step(1'b0, 1'b1, 12'h150, 12'h150);
        hold(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'hFFF, 12'h150);
        step(1'b0, 1'b1, 12'h100, 12'h150);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'hFFF, 12'h150);
        hold(2);
        check("no_fault", 32'(cell_fault), 32'd0);

        // Back to STEER, then four saturated samples on cell 0.
        step(1'b0, 1'b1, 12'h150, 12'h150);
        for (int i = 0; i < 40000 && m_state != 2; i++) hold(1);
        check("steer_again", 32'(en_steer), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 12'hFFF, 12'hF00);
        check("fault_set", 32'(cell_fault), 32'd1);
        hold(1);
        check("fault_idle", 32'(state_o), 32'd0);
        check("fault_en", 32'(en_steer), 32'd0);
        step(1'b0, 1'b1, 12'h150, 12'h150);
        hold(4);
        check("fault_sticky", 32'(cell_fault), 32'd1);
        check("fault_hold", 32'(state_o), 32'd0);
        step(1'b1, 1'b0, 0, 0);
        check("fault_rst", 32'(cell_fault), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
